// File: rtl/rr_grant_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time per owner.
// Grant index, valid flag and one-hot grant are all registered.
module rr_grant_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [3:0] gnt_q, gnt_d;

    logic       owner_req;
    logic [3:0] others;
    logic       others_pend;
    logic       hold_last;
    logic [2:0] sel_all;
    logic [2:0] sel_oth;

    // Returns {found, index} of the first set bit searching from p upward.
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [1:0] c;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            c = p + 2'(i);
            if (r[c]) pick = {1'b1, c};
        end
    endfunction

    assign owner_req   = req[idx_q];
    assign others      = req & ~(4'b0001 << idx_q);
    assign others_pend = |others;
    assign hold_last   = (hold_q == HOLD_LAST);
    assign sel_all     = pick(req, ptr_q);
    assign sel_oth     = pick(others, ptr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            hold_q  <= 8'd0;
            idx_q   <= 2'b00;
            valid_q <= 1'b0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (sel_all[2]) begin
                    state_d = GRANT;
                    idx_d   = sel_all[1:0];
                    valid_d = 1'b1;
                    ptr_d   = sel_all[1:0] + 2'd1;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                unique case (1'b1)
                    (others_pend && (!owner_req || hold_last)): begin
                        idx_d  = sel_oth[1:0];
                        ptr_d  = sel_oth[1:0] + 2'd1;
                        hold_d = 8'd0;
                    end
                    (!owner_req && !others_pend): begin
                        state_d = IDLE;
                        idx_d   = 2'b00;
                        valid_d = 1'b0;
                        hold_d  = 8'd0;
                    end
                    default: begin
                        hold_d = hold_last ? hold_q : hold_q + 8'd1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = 4'b0000;
        if (valid_d) gnt_d = 4'b0001 << idx_d;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule
